// File: rtl/eth_pkt_gen_if.sv
// eth_pkt_gen_if: byte-wide MAC transmit stream between the packet generator
// (master) and the MAC (slave). A byte moves on a cycle with tx_vld and tx_ack.
`timescale 1ns/1ps
interface eth_pkt_gen_if;
  logic       tx_vld;
  logic       tx_sof;
  logic       tx_eof;
  logic       tx_err;
  logic [7:0] tx_dat;
  logic       tx_ack;

  modport master (
    output tx_vld,
    output tx_sof,
    output tx_eof,
    output tx_err,
    output tx_dat,
    input  tx_ack
  );

  modport slave (
    input  tx_vld,
    input  tx_sof,
    input  tx_eof,
    input  tx_err,
    input  tx_dat,
    output tx_ack
  );
endinterface

// File: rtl/eth_pkt_gen.sv
// eth_pkt_gen: Ethernet test-frame generator for a byte-wide MAC transmit port.
// Sends bursts of frames (header: DST/SRC MAC, EtherType, 32-bit sequence
// number; payload: incrementing byte pattern) separated by a programmable gap.
// Optional feature: define ETH_PKT_GEN_ERR_INJ_EN to add the err_inj input,
// which marks a frame at its sof transfer so tx_err is raised on its eof byte.
`timescale 1ns/1ps
module eth_pkt_gen #(
  parameter logic [47:0] DST_MAC   = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC   = 48'h000000000000,
  parameter logic [15:0] ETHERTYPE = 16'hEBEB,
  parameter int          GAP_W     = 16,
  parameter int          CNT_W     = 16
) (
  input  logic             clk_mac,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [10:0]      len,
  input  logic [CNT_W-1:0] burst,
  input  logic [GAP_W-1:0] gap,
`ifdef ETH_PKT_GEN_ERR_INJ_EN
  input  logic             err_inj,
`endif
  eth_pkt_gen_if.master    tx,
  output logic             busy,
  output logic [CNT_W-1:0] frames_sent
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [10:0] MIN_LEN = 11'd60;
  localparam logic [10:0] MAX_LEN = 11'd1514;

  state_t           state;
  logic [10:0]      len_q;
  logic [CNT_W-1:0] burst_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] burst_cnt;
  logic [10:0]      byte_idx;
  logic [31:0]      seq;
  logic             stop_pend;

  logic             vld_q;
  logic             sof_q;
  logic             eof_q;
  logic [7:0]       dat_q;

`ifdef ETH_PKT_GEN_ERR_INJ_EN
  logic             err_q;
  logic             err_mark;
`endif

  // Byte value at position idx of the frame carrying sequence number sq.
  function automatic logic [7:0] frame_byte(input logic [10:0] idx,
                                            input logic [31:0] sq);
    int         i;
    logic [7:0] b;
    i = int'(idx);
    if (i < 6)
      b = 8'(DST_MAC >> (8 * (5 - i)));
    else if (i < 12)
      b = 8'(SRC_MAC >> (8 * (11 - i)));
    else if (i == 12)
      b = ETHERTYPE[15:8];
    else if (i == 13)
      b = ETHERTYPE[7:0];
    else if (i < 18)
      b = 8'(sq >> (8 * (17 - i)));
    else
      b = 8'(i - 18);
    return b;
  endfunction

  // Runt frames are padded up to the minimum and oversize ones cut to the
  // maximum untagged length, so the MAC always sees a legal frame size.
  function automatic logic [10:0] clamp_len(input logic [10:0] l);
    logic [10:0] r;
    if (l < MIN_LEN)
      r = MIN_LEN;
    else if (l > MAX_LEN)
      r = MAX_LEN;
    else
      r = l;
    return r;
  endfunction

  logic             xfer;
  logic [10:0]      next_idx;
  logic             next_is_last;
  logic             stop_seen;
  logic             burst_done;
  logic [31:0]      seq_next;
  logic [CNT_W-1:0] burst_cnt_next;

  assign xfer           = vld_q & tx.tx_ack;
  assign next_idx       = byte_idx + 11'd1;
  assign next_is_last   = (next_idx == (len_q - 11'd1));
  assign stop_seen      = stop_pend | stop;
  assign seq_next       = seq + 32'd1;
  assign burst_cnt_next = burst_cnt + CNT_W'(1);
  assign burst_done     = (burst_q != '0) && (burst_cnt_next == burst_q);

  assign tx.tx_vld = vld_q;
  assign tx.tx_sof = sof_q;
  assign tx.tx_eof = eof_q;
  assign tx.tx_dat = dat_q;
`ifdef ETH_PKT_GEN_ERR_INJ_EN
  assign tx.tx_err = err_q;
`else
  assign tx.tx_err = 1'b0;
`endif

  assign busy = (state != IDLE);

  // Frame sequencer: IDLE/SEND/GAP state machine driving the registered
  // stream outputs; a presented byte only changes after it is accepted.
  always_ff @(posedge clk_mac) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= MIN_LEN;
      burst_q     <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      burst_cnt   <= '0;
      byte_idx    <= '0;
      seq         <= '0;
      stop_pend   <= 1'b0;
      frames_sent <= '0;
      vld_q       <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      dat_q       <= '0;
`ifdef ETH_PKT_GEN_ERR_INJ_EN
      err_q       <= 1'b0;
      err_mark    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          stop_pend <= 1'b0;
          if (start) begin
            len_q     <= clamp_len(len);
            burst_q   <= burst;
            gap_q     <= gap;
            burst_cnt <= '0;
            byte_idx  <= '0;
            state     <= SEND;
            vld_q     <= 1'b1;
            sof_q     <= 1'b1;
            eof_q     <= 1'b0;
            dat_q     <= frame_byte(11'd0, seq);
`ifdef ETH_PKT_GEN_ERR_INJ_EN
            err_q     <= 1'b0;
            err_mark  <= 1'b0;
`endif
          end
        end

        SEND: begin
          if (stop)
            stop_pend <= 1'b1;
          if (xfer) begin
            if (!eof_q) begin
              byte_idx <= next_idx;
              dat_q    <= frame_byte(next_idx, seq);
              sof_q    <= 1'b0;
              eof_q    <= next_is_last;
`ifdef ETH_PKT_GEN_ERR_INJ_EN
              if (sof_q) begin
                err_mark <= err_inj;
                err_q    <= next_is_last & err_inj;
              end else begin
                err_q    <= next_is_last & err_mark;
              end
`endif
            end else begin
              frames_sent <= frames_sent + CNT_W'(1);
              seq         <= seq_next;
              burst_cnt   <= burst_cnt_next;
              byte_idx    <= '0;
              eof_q       <= 1'b0;
`ifdef ETH_PKT_GEN_ERR_INJ_EN
              err_q       <= 1'b0;
              err_mark    <= 1'b0;
`endif
              if (burst_done || stop_seen) begin
                state     <= IDLE;
                vld_q     <= 1'b0;
                sof_q     <= 1'b0;
                dat_q     <= '0;
                stop_pend <= 1'b0;
              end else if (gap_q != '0) begin
                state   <= GAP;
                gap_cnt <= gap_q;
                vld_q   <= 1'b0;
                sof_q   <= 1'b0;
              end else begin
                vld_q <= 1'b1;
                sof_q <= 1'b1;
                dat_q <= frame_byte(11'd0, seq_next);
              end
            end
          end
        end

        GAP: begin
          if (stop_seen) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
            dat_q     <= '0;
          end else if (gap_cnt == GAP_W'(1)) begin
            state    <= SEND;
            byte_idx <= '0;
            vld_q    <= 1'b1;
            sof_q    <= 1'b1;
            eof_q    <= 1'b0;
            dat_q    <= frame_byte(11'd0, seq);
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          vld_q <= 1'b0;
          sof_q <= 1'b0;
          eof_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_pkt_gen.sv
// tb_eth_pkt_gen: scoreboard bench for eth_pkt_gen. Stimulus pushes the
// expected byte stream of every frame it requests; a monitor pops and compares
// each accepted byte, checks hold-while-stalled and inter-frame gap length.
// Define ETH_PKT_GEN_ERR_INJ_EN to also exercise the err_inj feature.
`timescale 1ns/1ps
module tb_eth_pkt_gen;

  localparam logic [47:0] DST   = 48'hA1B2C3D4E5F6;
  localparam logic [47:0] SRC   = 48'h020304050607;
  localparam logic [15:0] ETYPE = 16'hEBEB;

  typedef struct packed {
    logic [7:0] dat;
    logic       sof;
    logic       eof;
    logic       err;
  } beat_t;

  logic        clk_mac = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [10:0] len;
  logic [15:0] burst;
  logic [15:0] gap;
  logic        busy;
  logic [15:0] frames_sent;
`ifdef ETH_PKT_GEN_ERR_INJ_EN
  logic        err_inj;
  int          errTarget = -1;
`endif

  eth_pkt_gen_if tx ();

  eth_pkt_gen #(
    .DST_MAC  (DST),
    .SRC_MAC  (SRC),
    .ETHERTYPE(ETYPE),
    .GAP_W    (16),
    .CNT_W    (16)
  ) dut (
    .clk_mac    (clk_mac),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .len        (len),
    .burst      (burst),
    .gap        (gap),
`ifdef ETH_PKT_GEN_ERR_INJ_EN
    .err_inj    (err_inj),
`endif
    .tx         (tx),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  always #5 clk_mac = ~clk_mac;

  beat_t expQ[$];
  int    tests = 0;
  int    fails = 0;
  int    modelSeq = 0;
  int    modelFrames = 0;
  int    transferCount = 0;
  int    sofCount = 0;
  int    eofCount = 0;
  int    expGap = -1;
  int    ackMode = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic int clampLen(input int l);
    return (l < 60) ? 60 : ((l > 1514) ? 1514 : l);
  endfunction

  function automatic logic [7:0] refByte(input int i, input logic [31:0] sq);
    logic [143:0] hdr;
    hdr = {DST, SRC, ETYPE, sq};
    if (i < 18) return hdr[143 - 8*i -: 8];
    return 8'((i - 18) % 256);
  endfunction

  task automatic pushFrame(input int rawLen, input bit errMark);
    int    l;
    beat_t b;
    l = clampLen(rawLen);
    for (int i = 0; i < l; i++) begin
      b.dat = refByte(i, 32'(modelSeq));
      b.sof = (i == 0);
      b.eof = (i == l - 1);
      b.err = errMark && (i == l - 1);
      expQ.push_back(b);
    end
    modelSeq++;
    modelFrames++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_mac);
      #1;
    end
  endtask

  // Queue nFrames expected frames, then pulse start with the given settings.
  task automatic applyStimulus(input int l, input int b, input int g,
                               input int nFrames, input int errIdx, input bit withStop);
    for (int f = 0; f < nFrames; f++) pushFrame(l, f == errIdx);
    transferCount = 0;
    sofCount = 0;
    eofCount = 0;
    @(posedge clk_mac);
    #1;
    start = 1'b1;
    stop  = withStop;
    len   = 11'(l);
    burst = 16'(b);
    gap   = 16'(g);
    @(posedge clk_mac);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    len   = 11'($urandom_range(0, 2047));
    burst = 16'($urandom_range(0, 9));
    gap   = 16'($urandom_range(0, 9));
  endtask

  task automatic waitIdle(input string name, input int maxCycles);
    int c = 0;
    while ((busy || expQ.size() != 0) && c < maxCycles) begin
      @(posedge clk_mac);
      #1;
      c++;
    end
    if (c >= maxCycles) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s timeout: busy=%0b, %0d bytes outstanding, required idle", name, busy, expQ.size());
    end
    checkOutput({name, " busy"}, longint'(busy), 0);
    checkOutput({name, " frames_sent"}, longint'(frames_sent), longint'(modelFrames % 65536));
    checkOutput({name, " bytes left"}, longint'(expQ.size()), 0);
  endtask

  // Block until a monitor counter reaches target or the budget expires.
  task automatic waitSof(input int target, input int maxCycles);
    int c = 0;
    while (sofCount < target && c < maxCycles) begin
      @(posedge clk_mac);
      #1;
      c++;
    end
    if (c >= maxCycles) begin
      tests++;
      fails++;
      $display("[TB] FAIL wait sof: got %0d, expected %0d", sofCount, target);
    end
  endtask

  task automatic waitEof(input int target, input int maxCycles);
    int c = 0;
    while (eofCount < target && c < maxCycles) begin
      @(posedge clk_mac);
      #1;
      c++;
    end
    if (c >= maxCycles) begin
      tests++;
      fails++;
      $display("[TB] FAIL wait eof: got %0d, expected %0d", eofCount, target);
    end
  endtask

  task automatic waitXfer(input int target, input int maxCycles);
    int c = 0;
    while (transferCount < target && c < maxCycles) begin
      @(posedge clk_mac);
      #1;
      c++;
    end
    if (c >= maxCycles) begin
      tests++;
      fails++;
      $display("[TB] FAIL wait transfers: got %0d, expected %0d", transferCount, target);
    end
  endtask

  // MAC-side acceptance pattern: always ready, alternating, or random.
  initial begin
    tx.tx_ack = 1'b1;
    forever begin
      @(posedge clk_mac);
      #1;
      case (ackMode)
        0:       tx.tx_ack = 1'b1;
        1:       tx.tx_ack = ~tx.tx_ack;
        default: tx.tx_ack = 1'($urandom_range(0, 1));
      endcase
    end
  end

`ifdef ETH_PKT_GEN_ERR_INJ_EN
  // Raise err_inj while the target frame's sof byte is on offer.
  initial begin
    err_inj = 1'b0;
    forever begin
      @(posedge clk_mac);
      #2;
      err_inj = (errTarget >= 0) && tx.tx_vld && tx.tx_sof && (sofCount == errTarget);
    end
  end
`endif

  // Monitor: compare accepted bytes against the scoreboard queue.
  initial begin
    beat_t cur;
    beat_t exp;
    beat_t held;
    bit    holdPending = 1'b0;
    bit    inGap = 1'b0;
    int    gapCount = 0;
    forever begin
      @(negedge clk_mac);
      cur = {tx.tx_dat, tx.tx_sof, tx.tx_eof, tx.tx_err};
      if (rst) begin
        holdPending = 1'b0;
        inGap = 1'b0;
      end else begin
        if (holdPending && tx.tx_vld) checkOutput("hold while stalled", longint'(cur), longint'(held));
        holdPending = 1'b0;
        if (inGap) begin
          if (tx.tx_vld) begin
            if (expGap >= 0) checkOutput("gap cycles", longint'(gapCount), longint'(expGap));
            inGap = 1'b0;
          end else if (!busy) begin
            inGap = 1'b0;
          end else begin
            gapCount++;
          end
        end
        if (tx.tx_vld && tx.tx_ack) begin
          transferCount++;
          if (tx.tx_sof) sofCount++;
          if (expQ.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected byte: got %0h, expected none", cur);
          end else begin
            exp = expQ.pop_front();
            checkOutput("stream byte", longint'(cur), longint'(exp));
          end
          if (tx.tx_eof) begin
            eofCount++;
            inGap = 1'b1;
            gapCount = 0;
          end
        end else if (tx.tx_vld) begin
          held = cur;
          holdPending = 1'b1;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL global timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int l;
    int b;
    int g;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    len = '0;
    burst = '0;
    gap = '0;
    cycles(3);
    rst = 1'b0;
    cycles(1);
    checkOutput("reset tx_vld", longint'(tx.tx_vld), 0);
    checkOutput("reset sof/eof/err", longint'({tx.tx_sof, tx.tx_eof, tx.tx_err}), 0);
    checkOutput("reset tx_dat", longint'(tx.tx_dat), 0);
    checkOutput("reset busy", longint'(busy), 0);
    checkOutput("reset frames_sent", longint'(frames_sent), 0);

    // Single 64-byte frame, always ready.
    ackMode = 0;
    expGap = 0;
    applyStimulus(64, 1, 0, 1, -1, 1'b0);
    waitIdle("single frame", 500);
    checkOutput("single frame transfers", longint'(transferCount), 64);

    // Runt length, three frames, gap of five; a start mid-burst is ignored.
    expGap = 5;
    applyStimulus(10, 3, 5, 3, -1, 1'b0);
    cycles(10);
    start = 1'b1;
    len = 11'd200;
    burst = 16'd5;
    cycles(1);
    start = 1'b0;
    waitIdle("burst of three", 1000);

    // Alternating acceptance, 100 bytes.
    ackMode = 1;
    expGap = -1;
    applyStimulus(100, 1, 0, 1, -1, 1'b0);
    waitIdle("stalled frame", 1000);
    checkOutput("stalled frame transfers", longint'(transferCount), 100);

    // Continuous mode ended by stop during frame index 4.
    ackMode = 0;
    expGap = 2;
    applyStimulus(70, 0, 2, 5, -1, 1'b0);
    waitSof(5, 2000);
    cycles(5);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    waitIdle("stop mid-frame", 1000);

    // Stop during the gap ends the burst on the next cycle.
    expGap = -1;
    applyStimulus(60, 0, 20, 1, -1, 1'b0);
    waitEof(1, 500);
    cycles(3);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    checkOutput("stop in gap busy", longint'(busy), 0);
    waitIdle("stop in gap", 100);

    // Start and stop together in IDLE: start wins.
    expGap = 1;
    applyStimulus(60, 2, 1, 2, -1, 1'b1);
    waitIdle("start with stop", 1000);

    // Length clamp boundaries.
    expGap = 0;
    applyStimulus(59, 1, 0, 1, -1, 1'b0);
    waitIdle("len 59", 500);
    applyStimulus(61, 1, 0, 1, -1, 1'b0);
    waitIdle("len 61", 500);
    applyStimulus(1515, 1, 0, 1, -1, 1'b0);
    waitIdle("len 1515", 3000);

    // Randomized bursts with random acceptance.
    for (int t = 0; t < 6; t++) begin
      l = $urandom_range(0, 300);
      b = $urandom_range(1, 3);
      g = $urandom_range(0, 4);
      ackMode = $urandom_range(0, 2);
      expGap = g;
      applyStimulus(l, b, g, b, -1, 1'b0);
      waitIdle("random burst", 20000);
    end

`ifdef ETH_PKT_GEN_ERR_INJ_EN
    // Error marking on the second of three frames.
    ackMode = 2;
    expGap = 1;
    errTarget = 1;
    applyStimulus(60, 3, 1, 3, 1, 1'b0);
    waitIdle("error inject", 2000);
    errTarget = -1;
`endif

    // Reset in the middle of a frame clears everything.
    ackMode = 0;
    expGap = -1;
    applyStimulus(80, 2, 0, 2, -1, 1'b0);
    waitXfer(30, 500);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    expQ.delete();
    modelSeq = 0;
    modelFrames = 0;
    checkOutput("mid-frame reset tx_vld", longint'(tx.tx_vld), 0);
    checkOutput("mid-frame reset busy", longint'(busy), 0);
    checkOutput("mid-frame reset frames_sent", longint'(frames_sent), 0);
    checkOutput("mid-frame reset tx_dat", longint'(tx.tx_dat), 0);
    cycles(2);
    applyStimulus(60, 1, 0, 1, -1, 1'b0);
    waitIdle("after reset", 500);

    cycles(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
